icache_refill: RTL and testbench

Refill engine that sits between the instruction cache and the byte-wide RAM arbiter. On an instruction-cache miss it requests the memory port and reads one 16-byte block as sixteen sequential byte reads. It assembles the bytes into a 128-bit line and delivers it to the cache as a single-cycle fill pulse (`memDataValid` / `memAddr` / `memDataIn`). It is the producer end of the cache's fill interface.

---
 rtl/icache_refill.sv | 97 +++++++++
 tb/tb_icache_refill.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: on a miss, reads one line from the byte-wide
// RAM port as sequential byte reads and hands the assembled line to the cache.
module icache_refill #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
    input  logic                        clkIn,
    input  logic                        resetIn,
    input  logic                        missIn,
    input  logic [31:0]                 missAddrIn,
    output logic                        memReqOut,
    input  logic                        memGrantIn,
    output logic [31:0]                 memAddrOut,
    input  logic [7:0]                  memByteIn,
    output logic                        memDataValid,
    output logic [31:BLOCK_WIDTH]       memAddr,
    output logic [BLOCK_SIZE*8-1:0]     memDataIn
);

    typedef enum logic [1:0] {IDLE, WAIT_GRANT, READ, DONE} state_t;

    state_t                     state_q;
    logic [BLOCK_WIDTH:0]       cnt_q;
    logic [31:BLOCK_WIDTH]      base_q;
    logic [BLOCK_SIZE*8-1:0]    line_q;
    logic                       req_q;
    logic                       valid_q;

    logic [BLOCK_WIDTH-1:0]     lane;
    logic [BLOCK_WIDTH-1:0]     offs;
    logic                       cnt_last;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^missAddrIn[BLOCK_WIDTH-1:0];

    // cnt reaches BLOCK_SIZE exactly once; its top bit marks the final capture,
    // where the address stays parked on the last byte instead of wrapping.
    assign cnt_last = cnt_q[BLOCK_WIDTH];

    always_comb begin
        lane       = cnt_q[BLOCK_WIDTH-1:0] - 1'b1;
        offs       = cnt_last ? '1 : cnt_q[BLOCK_WIDTH-1:0];
        memAddrOut = '0;
        if (state_q == READ)
            memAddrOut = {base_q, offs};
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            line_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (missIn) begin
                        base_q  <= missAddrIn[31:BLOCK_WIDTH];
                        req_q   <= 1'b1;
                        state_q <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    if (memGrantIn) begin
                        cnt_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    // RAM data lags the address by one cycle, so lane cnt-1 lands now.
                    if (cnt_q != '0)
                        line_q[{lane, 3'b000} +: 8] <= memByteIn;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_last) begin
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memReqOut    = req_q;
    assign memDataValid = valid_q;
    assign memAddr      = base_q;
    assign memDataIn    = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a RAM model that returns A[7:0] for address A.
module tb_icache_refill;

    logic           clkIn = 1'b0;
    logic           resetIn;
    logic           missIn;
    logic [31:0]    missAddrIn;
    logic           memReqOut;
    logic           memGrantIn;
    logic [31:0]    memAddrOut;
    logic [7:0]     memByteIn;
    logic           memDataValid;
    logic [31:4]    memAddr;
    logic [127:0]   memDataIn;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE_123 = 128'h3F3E3D3C3B3A39383736353433323130;
    localparam logic [127:0] LINE_LO  = 128'h0F0E0D0C0B0A09080706050403020100;

    icache_refill #(.BLOCK_WIDTH(4)) dut (
        .clkIn        (clkIn),
        .resetIn      (resetIn),
        .missIn       (missIn),
        .missAddrIn   (missAddrIn),
        .memReqOut    (memReqOut),
        .memGrantIn   (memGrantIn),
        .memAddrOut   (memAddrOut),
        .memByteIn    (memByteIn),
        .memDataValid (memDataValid),
        .memAddr      (memAddr),
        .memDataIn    (memDataIn)
    );

    always #5 clkIn = ~clkIn;

    // byte-wide RAM: data for an address appears the cycle after it
    always @(posedge clkIn) memByteIn <= memAddrOut[7:0];

    task automatic test_reset();
        resetIn = 1'b1; missIn = 1'b0; memGrantIn = 1'b0; missAddrIn = '0;
        repeat (2) @(posedge clkIn);
        #1 resetIn = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clkIn); #1;
            checks++;
            if (memReqOut !== 1'b0) begin errors++; $display("FAIL reset_req cycle %0d got %b want 0", n, memReqOut); end
            checks++;
            if (memDataValid !== 1'b0) begin errors++; $display("FAIL reset_valid cycle %0d got %b want 0", n, memDataValid); end
            checks++;
            if (memAddrOut !== 32'h0) begin errors++; $display("FAIL reset_addrout cycle %0d got %h want 0", n, memAddrOut); end
        end
        checks++;
        if (memAddr !== 28'h0) begin errors++; $display("FAIL reset_memaddr got %h want 0", memAddr); end
        checks++;
        if (memDataIn !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", memDataIn); end
    endtask

    // One complete refill starting from IDLE; gdelay = cycles grant is withheld.
    task automatic test_refill(input string name, input logic [31:0] addr, input int gdelay,
                               input bit poke_addr, input logic [27:0] exp_base,
                               input logic [127:0] exp_line);
        int          done_at;
        int          k;
        logic [31:0] exp_a;
        done_at    = 19 + gdelay;
        missAddrIn = addr;
        missIn     = 1'b1;
        memGrantIn = (gdelay == 0);
        for (int n = 1; n <= done_at + 2; n++) begin
            @(posedge clkIn); #1;
            checks++;
            if (memReqOut !== (n <= done_at - 1))
                begin errors++; $display("FAIL %s_req cycle %0d got %b want %b", name, n, memReqOut, (n <= done_at - 1)); end
            exp_a = 32'h0;
            if (n >= 2 + gdelay && n <= done_at - 1) begin
                k = n - 2 - gdelay;
                exp_a = {exp_base, (k > 15) ? 4'hF : 4'(k)};
            end
            checks++;
            if (memAddrOut !== exp_a)
                begin errors++; $display("FAIL %s_addrout cycle %0d got %h want %h", name, n, memAddrOut, exp_a); end
            checks++;
            if (memDataValid !== (n == done_at))
                begin errors++; $display("FAIL %s_valid cycle %0d got %b want %b", name, n, memDataValid, (n == done_at)); end
            if (n == done_at) begin
                checks++;
                if (memAddr !== exp_base)
                    begin errors++; $display("FAIL %s_memaddr got %h want %h", name, memAddr, exp_base); end
                checks++;
                if (memDataIn !== exp_line)
                    begin errors++; $display("FAIL %s_data got %h want %h", name, memDataIn, exp_line); end
            end
            missIn     = 1'b0;
            memGrantIn = (n >= gdelay + 1);
            if (poke_addr && n == 10) missAddrIn = 32'h0000_4000;
        end
        memGrantIn = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit bad_valid = 1'b0;
        bit bad_req   = 1'b0;
        missAddrIn = 32'h0000_1238; missIn = 1'b1; memGrantIn = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clkIn); #1;
            missIn = 1'b0;
        end
        checks++;
        if (memAddrOut !== 32'h0000_1239) begin errors++; $display("FAIL rstmid_cnt9 got %h want 00001239", memAddrOut); end
        resetIn = 1'b1;
        @(posedge clkIn); #1;
        resetIn = 1'b0;
        checks++;
        if (memReqOut !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b want 0", memReqOut); end
        checks++;
        if (memAddrOut !== 32'h0) begin errors++; $display("FAIL rstmid_addrout got %h want 0", memAddrOut); end
        checks++;
        if (memDataValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", memDataValid); end
        checks++;
        if (memAddr !== 28'h0) begin errors++; $display("FAIL rstmid_memaddr got %h want 0", memAddr); end
        checks++;
        if (memDataIn !== 128'h0) begin errors++; $display("FAIL rstmid_data got %h want 0", memDataIn); end
        for (int n = 0; n < 25; n++) begin
            @(posedge clkIn); #1;
            if (memDataValid !== 1'b0) bad_valid = 1'b1;
            if (memReqOut !== 1'b0) bad_req = 1'b1;
        end
        checks++;
        if (bad_valid) begin errors++; $display("FAIL rstmid_late_pulse got 1 want 0"); end
        checks++;
        if (bad_req) begin errors++; $display("FAIL rstmid_late_req got 1 want 0"); end
        memGrantIn = 1'b0;
    endtask

    task automatic test_back_to_back();
        int           npulse = 0;
        int           p1 = -1;
        int           p2 = -1;
        logic [27:0]  a1 = '0;
        logic [27:0]  a2 = '0;
        logic [127:0] d1 = '0;
        logic [127:0] d2 = '0;
        missAddrIn = 32'h0000_0100; missIn = 1'b1; memGrantIn = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clkIn); #1;
            if (memDataValid === 1'b1) begin
                npulse++;
                if (npulse == 1) begin
                    p1 = n; a1 = memAddr; d1 = memDataIn;
                    missAddrIn = 32'h0000_0200;
                end else if (npulse == 2) begin
                    p2 = n; a2 = memAddr; d2 = memDataIn;
                end
            end
            if (npulse == 1 && n == p1 + 2) missIn = 1'b0;
        end
        missIn = 1'b0; memGrantIn = 1'b0;
        checks++;
        if (npulse != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", npulse); end
        checks++;
        if (p1 != 19) begin errors++; $display("FAIL b2b_first_at got %0d want 19", p1); end
        checks++;
        if (p2 - p1 != 20) begin errors++; $display("FAIL b2b_spacing got %0d want 20", p2 - p1); end
        checks++;
        if (a1 !== 28'h10) begin errors++; $display("FAIL b2b_addr1 got %h want 0000010", a1); end
        checks++;
        if (a2 !== 28'h20) begin errors++; $display("FAIL b2b_addr2 got %h want 0000020", a2); end
        checks++;
        if (d1 !== LINE_LO) begin errors++; $display("FAIL b2b_data1 got %h want %h", d1, LINE_LO); end
        checks++;
        if (d2 !== LINE_LO) begin errors++; $display("FAIL b2b_data2 got %h want %h", d2, LINE_LO); end
    endtask

    initial begin
        resetIn = 1'b1; missIn = 1'b0; memGrantIn = 1'b0; missAddrIn = '0;
        test_reset();
        test_refill("basic",  32'h0000_1238, 0, 1'b0, 28'h123, LINE_123);
        test_refill("gdelay", 32'h0000_1238, 7, 1'b0, 28'h123, LINE_123);
        test_refill("ignore", 32'h0000_1238, 0, 1'b1, 28'h123, LINE_123);
        test_refill("second", 32'h0000_4000, 0, 1'b0, 28'h400, LINE_LO);
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
